// File: rtl/io_pkg.sv
// Shared register-map constants and address decode for the MMIO switch/LED controller.
package io_pkg;

  localparam int unsigned MaxDataW = 32;
  localparam int unsigned MaxNIn   = 8;
  localparam int unsigned MaxNOut  = 8;
  localparam int unsigned BusW     = 32;
  localparam int unsigned InBase   = 0;

  typedef enum logic [2:0] {
    RegIn,
    RegOut,
    RegStatus,
    RegIrqEn,
    RegNone
  } reg_kind_e;

  function automatic int unsigned out_base(input int unsigned n_in);
    return InBase + n_in;
  endfunction

  function automatic int unsigned status_off(input int unsigned n_in, input int unsigned n_out);
    return out_base(n_in) + n_out;
  endfunction

  function automatic int unsigned irq_en_off(input int unsigned n_in, input int unsigned n_out);
    return status_off(n_in, n_out) + 1;
  endfunction

  function automatic reg_kind_e decode_addr(input int unsigned a, input int unsigned n_in,
                                            input int unsigned n_out);
    if (a < out_base(n_in)) begin
      return RegIn;
    end else if (a < status_off(n_in, n_out)) begin
      return RegOut;
    end else if (a == status_off(n_in, n_out)) begin
      return RegStatus;
    end else if (a == irq_en_off(n_in, n_out)) begin
      return RegIrqEn;
    end
    return RegNone;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One input channel: 2-flop synchronizer, stability counter and debounced-change detect.
module io_debounce
  import io_pkg::*;
#(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              changed
);

  localparam int unsigned     CntW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic [DATA_W-1:0] sync1_q, sync2_q;
  logic [DATA_W-1:0] cand_q, cand_d;
  logic [DATA_W-1:0] deb_q, deb_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
      // Commit once the candidate has held for the full window.
      if (cnt_d == CntMax) begin
        deb_d = cand_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      deb_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  assign dout    = deb_q;
  assign changed = (deb_d != deb_q);

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO register block for debounced switch inputs, registered LED outputs and a change interrupt.
module mmio_io_ctrl
  import io_pkg::*;
#(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned N_IN       = 1,
  parameter int unsigned N_OUT      = 1,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic                    clk,
  input  logic                    fpga_rst,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [BusW-1:0]         wdata,
  output logic [BusW-1:0]         rdata,
  output logic                    rvalid,
  input  logic [N_IN*DATA_W-1:0]  io_rdata,
  output logic [N_OUT*DATA_W-1:0] io_wdata,
  output logic                    irq
);

  localparam int unsigned OutBase = out_base(N_IN);

  logic [N_IN*DATA_W-1:0]  deb;
  logic [N_IN-1:0]         changed;
  logic [N_OUT*DATA_W-1:0] out_q, out_d;
  logic [N_IN-1:0]         status_q, status_d;
  logic [N_IN-1:0]         irq_en_q, irq_en_d;
  logic [N_IN-1:0]         wr_clr;
  logic [BusW-1:0]         rdata_q, rdata_d;
  logic [BusW-1:0]         rd_val;
  logic                    rvalid_q, irq_q, irq_d;
  int unsigned             a;
  reg_kind_e               kind;
  logic                    unused_wdata;

  assign unused_wdata = ^wdata;

  for (genvar k = 0; k < N_IN; k++) begin : gen_in
    io_debounce #(
      .DATA_W     (DATA_W),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst_n   (fpga_rst),
      .din     (io_rdata[k*DATA_W +: DATA_W]),
      .dout    (deb[k*DATA_W +: DATA_W]),
      .changed (changed[k])
    );
  end

  always_comb begin
    a    = 32'(addr);
    kind = decode_addr(a, N_IN, N_OUT);
  end

  // Read mux sees pre-write register values, so a simultaneous write never leaks into rdata.
  always_comb begin
    rd_val = '0;
    unique case (kind)
      RegIn: begin
        for (int unsigned k = 0; k < N_IN; k++) begin
          if (a == InBase + k) rd_val[DATA_W-1:0] = deb[k*DATA_W +: DATA_W];
        end
      end
      RegOut: begin
        for (int unsigned k = 0; k < N_OUT; k++) begin
          if (a == OutBase + k) rd_val[DATA_W-1:0] = out_q[k*DATA_W +: DATA_W];
        end
      end
      RegStatus: rd_val[N_IN-1:0] = status_q;
      RegIrqEn:  rd_val[N_IN-1:0] = irq_en_q;
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    out_d    = out_q;
    irq_en_d = irq_en_q;
    wr_clr   = '0;
    if (wr_en) begin
      unique case (kind)
        RegOut: begin
          for (int unsigned k = 0; k < N_OUT; k++) begin
            if (a == OutBase + k) out_d[k*DATA_W +: DATA_W] = wdata[DATA_W-1:0];
          end
        end
        RegStatus: wr_clr   = wdata[N_IN-1:0];
        RegIrqEn:  irq_en_d = wdata[N_IN-1:0];
        default:   wr_clr   = '0;
      endcase
    end
    // A change landing on the same edge as its clear wins.
    status_d = (status_q & ~wr_clr) | changed;
    irq_d    = |(status_q & irq_en_q);
    rdata_d  = rd_en ? rd_val : '0;
  end

  always_ff @(posedge clk or negedge fpga_rst) begin
    if (!fpga_rst) begin
      out_q    <= '0;
      status_q <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      status_q <= status_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rd_en;
      irq_q    <= irq_d;
    end
  end

  assign io_wdata = out_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl: register-access vector table plus debounce/irq/reset sequences.
module tb_mmio_io_ctrl;

  logic        clk = 1'b0;
  logic        fpga_rst;
  logic [4:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic [23:0] io_rdata;
  logic [47:0] io_wdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  mmio_io_ctrl #(
    .DATA_W     (24),
    .N_IN       (1),
    .N_OUT      (2),
    .DEB_CYCLES (16),
    .ADDR_W     (5)
  ) dut (
    .clk      (clk),
    .fpga_rst (fpga_rst),
    .addr     (addr),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .io_rdata (io_rdata),
    .io_wdata (io_wdata),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [4:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [47:0] exp_io;
  } vec_t;

  localparam int NVec = 19;
  vec_t vecs [NVec];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [4:0] a,
                              input logic [31:0] wd, input logic [31:0] exp_rd,
                              input logic [47:0] exp_io);
    vec_t v;
    v.wr = wr; v.rd = rd; v.a = a; v.wd = wd; v.exp_rd = exp_rd; v.exp_io = exp_io;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    rd_en = 1'b1; addr = a;
    cyc();
    rd_en = 1'b0;
    chk({name, " rvalid"}, 64'(rvalid), 64'd1);
    chk({name, " rdata"}, 64'(rdata), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int bad;

    vecs[0]  = mk(0, 1, 5'd1,  32'h0,          32'h0,          48'h0);
    vecs[1]  = mk(1, 0, 5'd1,  32'hAB12_3456,  32'h0,          {24'h0, 24'h123456});
    vecs[2]  = mk(0, 1, 5'd1,  32'h0,          32'h0012_3456,  {24'h0, 24'h123456});
    vecs[3]  = mk(1, 0, 5'd2,  32'hFFFF_1234,  32'h0,          {24'hFF1234, 24'h123456});
    vecs[4]  = mk(0, 1, 5'd2,  32'h0,          32'h00FF_1234,  {24'hFF1234, 24'h123456});
    vecs[5]  = mk(0, 1, 5'd1,  32'h0,          32'h0012_3456,  {24'hFF1234, 24'h123456});
    vecs[6]  = mk(1, 0, 5'd0,  32'hDEAD_BEEF,  32'h0,          {24'hFF1234, 24'h123456});
    vecs[7]  = mk(0, 1, 5'd0,  32'h0,          32'h0,          {24'hFF1234, 24'h123456});
    vecs[8]  = mk(0, 1, 5'd5,  32'h0,          32'h0,          {24'hFF1234, 24'h123456});
    vecs[9]  = mk(0, 1, 5'd31, 32'h0,          32'h0,          {24'hFF1234, 24'h123456});
    vecs[10] = mk(0, 1, 5'd3,  32'h0,          32'h0,          {24'hFF1234, 24'h123456});
    vecs[11] = mk(1, 0, 5'd4,  32'hFFFF_FFFF,  32'h0,          {24'hFF1234, 24'h123456});
    vecs[12] = mk(0, 1, 5'd4,  32'h0,          32'h1,          {24'hFF1234, 24'h123456});
    vecs[13] = mk(1, 0, 5'd5,  32'hFFFF_FFFF,  32'h0,          {24'hFF1234, 24'h123456});
    vecs[14] = mk(1, 1, 5'd1,  32'h0000_0055,  32'h0012_3456,  {24'hFF1234, 24'h000055});
    vecs[15] = mk(0, 1, 5'd1,  32'h0,          32'h0000_0055,  {24'hFF1234, 24'h000055});
    vecs[16] = mk(1, 0, 5'd4,  32'h0,          32'h0,          {24'hFF1234, 24'h000055});
    vecs[17] = mk(0, 1, 5'd4,  32'h0,          32'h0,          {24'hFF1234, 24'h000055});
    vecs[18] = mk(0, 0, 5'd0,  32'h0,          32'h0,          {24'hFF1234, 24'h000055});

    fpga_rst = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0; io_rdata = '0;
    repeat (3) cyc();
    chk("reset rvalid", 64'(rvalid), 64'd0);
    chk("reset rdata", 64'(rdata), 64'd0);
    chk("reset irq", 64'(irq), 64'd0);
    chk("reset io_wdata", 64'(io_wdata), 64'd0);
    fpga_rst = 1'b1;
    cyc();

    // Register access table.
    for (int i = 0; i < NVec; i++) begin
      wr_en = vecs[i].wr; rd_en = vecs[i].rd; addr = vecs[i].a; wdata = vecs[i].wd;
      cyc();
      wr_en = 1'b0; rd_en = 1'b0;
      chk($sformatf("vec%0d rvalid", i), 64'(rvalid), 64'(vecs[i].rd));
      chk($sformatf("vec%0d rdata", i), 64'(rdata), 64'(vecs[i].exp_rd));
      chk($sformatf("vec%0d io_wdata", i), 64'(io_wdata), 64'(vecs[i].exp_io));
    end

    // Bouncing input never settles long enough to be accepted.
    for (int i = 0; i < 100; i++) begin
      if (i % 5 == 0) io_rdata[0] = ~io_rdata[0];
      rd_en = (i % 10 == 4); addr = 5'd0;
      cyc();
      if (i % 10 == 4) begin
        rd_en = 1'b0;
        chk($sformatf("bounce IN0 @%0d", i), 64'({rvalid, rdata}), 64'({1'b1, 32'h0}));
      end
    end
    rd_en = 1'b0;
    read_chk("bounce STATUS", 5'd3, 32'h0);

    // Stable input accepted after the debounce window.
    io_rdata = 24'h00A5A5;
    repeat (20) cyc();
    read_chk("stable IN0", 5'd0, 32'h0000_A5A5);
    read_chk("stable STATUS", 5'd3, 32'h1);
    chk("stable irq", 64'(irq), 64'd0);

    // irq rises on edge 19 after the input change: 2 sync + 16 window, then one register stage.
    write(5'd3, 32'h1);
    read_chk("cleared STATUS", 5'd3, 32'h0);
    write(5'd4, 32'h1);
    io_rdata = 24'h000001;
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (irq && first == 0) first = n;
    end
    chk("irq rise cycle", 64'(first), 64'd19);
    wr_en = 1'b1; addr = 5'd3; wdata = 32'h1;
    cyc();
    wr_en = 1'b0;
    chk("irq on clear edge", 64'(irq), 64'd1);
    cyc();
    chk("irq after clear", 64'(irq), 64'd0);
    read_chk("STATUS after clear", 5'd3, 32'h0);

    // Clear issued on the very edge a new change lands: set wins.
    io_rdata = 24'h000002;
    repeat (17) cyc();
    wr_en = 1'b1; addr = 5'd3; wdata = 32'h1;
    cyc();
    wr_en = 1'b0;
    read_chk("set-wins STATUS", 5'd3, 32'h1);
    read_chk("set-wins IN0", 5'd0, 32'h0000_0002);

    // Reset during a pending read.
    write(5'd3, 32'h1);
    io_rdata = 24'h0;
    repeat (22) cyc();
    chk("pre-reset irq", 64'(irq), 64'd1);
    rd_en = 1'b1; addr = 5'd1;
    #2;
    fpga_rst = 1'b0;
    #1;
    chk("mid-reset rvalid", 64'(rvalid), 64'd0);
    chk("mid-reset rdata", 64'(rdata), 64'd0);
    chk("mid-reset irq", 64'(irq), 64'd0);
    chk("mid-reset io_wdata", 64'(io_wdata), 64'd0);
    cyc();
    rd_en = 1'b0;
    fpga_rst = 1'b1;
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      cyc();
      if (rvalid || irq || rdata != 32'h0 || io_wdata != 48'h0) bad++;
    end
    chk("post-reset quiet cycles", 64'(bad), 64'd0);
    read_chk("post-reset STATUS", 5'd3, 32'h0);
    read_chk("post-reset IRQ_EN", 5'd4, 32'h0);
    read_chk("post-reset OUT1", 5'd2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_io_ctrl.md
MMIO_IO_CTRL -- requirements
Module: mmio_io_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning the width of each IO channel (1..32).
REQ-002 SHALL have parameter N_IN, default 1, meaning the number of input (switch) channels (1..8).
REQ-003 SHALL have parameter N_OUT, default 1, meaning the number of output (LED) channels (1..8).
REQ-004 SHALL have parameter DEB_CYCLES, default 16, meaning the debounce stability window in clk cycles (>=2).
REQ-005 SHALL have parameter ADDR_W, default 5, meaning the word-offset address width.
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 fpga_rst  in  1  reset, asynchronous, active-low.
REQ-008 addr  in  ADDR_W  word offset of the register access.
REQ-009 wr_en  in  1  write strobe, one cycle per write.
REQ-010 rd_en  in  1  read strobe, one cycle per read.
REQ-011 wdata  in  32  write data.
REQ-012 rdata  out  32  read data, valid while rvalid is high.
REQ-013 rvalid  out  1  read-data-valid pulse.
REQ-014 io_rdata  in  N_IN*DATA_W  raw asynchronous input channels, channel k at bits [k*DATA_W +: DATA_W].
REQ-015 io_wdata  out  N_OUT*DATA_W  registered output channels, packed the same way.
REQ-016 irq  out  1  level interrupt request.

Function
REQ-017 Register map SHALL be: offsets 0..N_IN-1 IN[k] (RO); N_IN..N_IN+N_OUT-1 OUT[k] (RW); N_IN+N_OUT STATUS (W1C, bit k = change flag of IN[k]); N_IN+N_OUT+1 IRQ_EN (RW, bit k).
REQ-018 Every io_rdata bit SHALL pass a 2-flop synchronizer before any other use.
REQ-019 Per input channel, a counter SHALL reset to 0 whenever the synchronized value differs from the candidate value and increment otherwise, saturating at DEB_CYCLES-1.
REQ-020 The debounced value of IN[k] SHALL update on the cycle the counter reaches DEB_CYCLES-1 with an unchanged candidate; the worst-case latency from stable input to IN[k] update is 2+DEB_CYCLES cycles.
REQ-021 When IN[k]'s debounced value changes, STATUS bit k SHALL set on the same edge.
REQ-022 A STATUS write SHALL clear each bit written as 1; if a clear and a set hit the same bit in the same cycle, set SHALL win.
REQ-023 irq SHALL be the registered OR of (STATUS & IRQ_EN) and SHALL assert one cycle after its cause.
REQ-024 A read SHALL have latency 1: rvalid pulses high exactly one cycle after rd_en and rdata carries the addressed value zero-extended from DATA_W (or N_IN) bits; rdata SHALL be 0 whenever rvalid is low.
REQ-025 A write to OUT[k] SHALL load wdata[DATA_W-1:0] into io_wdata channel k on that edge; upper bits are ignored.
REQ-026 Reads or writes to unmapped offsets and writes to IN[k] SHALL have no effect; an unmapped read returns 0 with rvalid.
REQ-027 If wr_en and rd_en are both high, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-028 Back-to-back reads on consecutive cycles SHALL each produce their own rvalid pulse.

Reset
REQ-029 While fpga_rst is low: io_wdata=0, rdata=0, rvalid=0, irq=0, STATUS=0, IRQ_EN=0, debounced values=0, counters=0, synchronizers=0.
REQ-030 Reset asserted mid-debounce or mid-read SHALL abort the operation; no rvalid or STATUS set SHALL occur after release until new stimulus arrives.

Structure
REQ-031 The register-offset constants, the STATUS/IRQ_EN offset formulas and the maximum-parameter limits SHALL live in the shared package io_pkg.
REQ-032 Per-channel synchronizer, debounce counter and change detect SHALL be one sub-module, io_debounce, instantiated N_IN times via generate.

Verification
REQ-033 After reset release, drive io_rdata=24'h00A5A5 stable, wait 20 cycles, read offset 0 -> rvalid one cycle later, rdata=32'h00A5A5, STATUS=1, irq=0.
REQ-034 Toggle an input bit every 5 cycles with DEB_CYCLES=16 for 100 cycles -> IN[0] never changes, STATUS stays 0.
REQ-035 Write IRQ_EN=1, then change the input -> irq rises exactly one cycle after STATUS[0] sets; writing STATUS=1 clears irq the following cycle.
REQ-036 With N_OUT=2, write 32'hFFFF_1234 to offset N_IN+1 -> io_wdata[47:24]=24'hFF1234 and channel 0 is unchanged; read back returns 32'h00FF1234.
REQ-037 Issue a STATUS clear on the same cycle a new debounced change lands -> STATUS bit remains 1.
REQ-038 Assert fpga_rst low for 1 cycle while a read is pending -> no rvalid, all outputs 0, and io_wdata=0 after release.
